// File: rtl/xunitf_sched.sv
`default_nettype none
// =====================================================================
// xunitf_sched : buffers SHA-256 (W,K) round pairs and sequences the
//                non-stallable xunitF FU over NCHUNKS chained chunks.
// Revision     : 1.0
// =====================================================================
module xunitf_sched #(
    parameter int DATA_W  = 32,
    parameter int ROUNDS  = 16,
    parameter int NCHUNKS = 4,
    parameter int LATENCY = 2,
    parameter int DELAY_W = 8,
    parameter int FEEDFWD = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DELAY_W-1:0]    delay_cfg,
    input  logic [8*DATA_W-1:0]   state_in,
    input  logic                  wk_valid,
    input  logic [DATA_W-1:0]     wk_w,
    input  logic [DATA_W-1:0]     wk_k,
    output logic                  wk_ready,
    output logic                  fu_run,
    output logic [8*DATA_W-1:0]   fu_state,
    output logic [DATA_W-1:0]     fu_w,
    output logic [DATA_W-1:0]     fu_k,
    output logic [DELAY_W-1:0]    fu_delay,
    input  logic [8*DATA_W-1:0]   fu_out,
    output logic                  busy,
    output logic                  done,
    output logic [8*DATA_W-1:0]   digest,
    output logic                  digest_valid
);

    localparam int PTR_W = $clog2(ROUNDS + 1);
    localparam int IDX_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam int CNT_W = $clog2(ROUNDS + (1 << DELAY_W) + LATENCY);
    localparam int CHK_W = $clog2(NCHUNKS + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FILL   = 3'd1,
        LAUNCH = 3'd2,
        FEED   = 3'd3,
        DRAIN  = 3'd4,
        FINAL  = 3'd5
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [DATA_W-1:0]   buf_w [ROUNDS];
    logic [DATA_W-1:0]   buf_k [ROUNDS];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CHK_W-1:0]    chunk_cnt;
    logic [CNT_W-1:0]    lat_cnt;
    logic [8*DATA_W-1:0] init_reg;
    logic [8*DATA_W-1:0] ff_sum;
    logic                accept;
    logic                feeding;
    logic                capture;
    logic                begin_blk;
    logic                launch_ld;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        feeding    = 1'b0;
        capture    = 1'b0;
        begin_blk  = 1'b0;
        launch_ld  = 1'b0;
        case (state)
            IDLE: begin
                // a start landing on the done cycle is deliberately dropped
                if (start && !done) begin
                    next_state = FILL;
                    begin_blk  = 1'b1;
                end
            end
            FILL: begin
                accept = wk_valid && wk_ready;
                if (accept && wr_ptr == PTR_W'(ROUNDS - 1)) begin
                    next_state = LAUNCH;
                    launch_ld  = 1'b1;
                end
            end
            LAUNCH: begin
                feeding    = 1'b1;
                next_state = FEED;
            end
            FEED: begin
                feeding = (rd_ptr != PTR_W'(ROUNDS));
                if (!feeding) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (lat_cnt == '0) begin
                    capture    = 1'b1;
                    next_state = (chunk_cnt < CHK_W'(NCHUNKS - 1)) ? FILL : FINAL;
                end
            end
            FINAL: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    for (genvar j = 0; j < 8; j++) begin : g_word
        if (FEEDFWD != 0) begin : g_ff
            assign ff_sum[j*DATA_W +: DATA_W] = init_reg[j*DATA_W +: DATA_W]
                                              + fu_state[j*DATA_W +: DATA_W];
        end else begin : g_raw
            assign ff_sum[j*DATA_W +: DATA_W] = fu_state[j*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wk_ready     <= 1'b0;
            fu_run       <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            digest_valid <= 1'b0;
            digest       <= '0;
            fu_state     <= '0;
            fu_w         <= '0;
            fu_k         <= '0;
            fu_delay     <= '0;
            init_reg     <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            chunk_cnt    <= '0;
            lat_cnt      <= '0;
            for (int i = 0; i < ROUNDS; i++) begin
                buf_w[i] <= '0;
                buf_k[i] <= '0;
            end
        end else begin
            wk_ready <= (next_state == FILL);
            fu_run   <= (next_state == LAUNCH);
            busy     <= (next_state != IDLE);
            done     <= (state == FINAL);

            if (lat_cnt != '0) begin
                lat_cnt <= lat_cnt - CNT_W'(1);
            end

            if (begin_blk) begin
                init_reg     <= state_in;
                fu_state     <= state_in;
                fu_delay     <= delay_cfg;
                chunk_cnt    <= '0;
                digest_valid <= 1'b0;
                wr_ptr       <= '0;
                rd_ptr       <= '0;
            end

            if (accept) begin
                buf_w[wr_ptr[IDX_W-1:0]] <= wk_w;
                buf_k[wr_ptr[IDX_W-1:0]] <= wk_k;
                wr_ptr                   <= wr_ptr + PTR_W'(1);
            end

            // counter is armed so that it reads ROUNDS+delay+LATENCY during LAUNCH
            if (launch_ld) begin
                lat_cnt <= CNT_W'(ROUNDS + LATENCY) + CNT_W'(fu_delay);
                wr_ptr  <= '0;
                rd_ptr  <= '0;
            end

            if (feeding) begin
                fu_w   <= buf_w[rd_ptr[IDX_W-1:0]];
                fu_k   <= buf_k[rd_ptr[IDX_W-1:0]];
                rd_ptr <= rd_ptr + PTR_W'(1);
            end

            if (capture) begin
                fu_state  <= fu_out;
                chunk_cnt <= chunk_cnt + CHK_W'(1);
            end

            if (state == FINAL) begin
                digest       <= ff_sum;
                digest_valid <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_xunitf_sched.sv
`default_nettype none
// =====================================================================
// tb_xunitf_sched : self-checking bench with a behavioural xunitF model
//                   and a whole-block SHA-256 reference.
// Revision        : 1.0
// =====================================================================
module tb_xunitf_sched;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start0 = 1'b0;
    logic         start1 = 1'b0;
    logic [7:0]   delay_cfg = '0;
    logic [255:0] state_in = '0;
    logic         wk_valid = 1'b0;
    logic [31:0]  wk_w = '0;
    logic [31:0]  wk_k = '0;

    logic         wk_ready0, fu_run0, busy0, done0, digest_valid0;
    logic [255:0] fu_state0, digest0, fu_out0;
    logic [31:0]  fu_w0, fu_k0;
    logic [7:0]   fu_delay0;
    logic         wk_ready1, fu_run1, busy1, done1, digest_valid1;
    logic [255:0] fu_state1, digest1, fu_out1;
    logic [31:0]  fu_w1, fu_k1;
    logic [7:0]   fu_delay1;

    always #5 clk = ~clk;

    xunitf_sched dut0 (
        .clk(clk), .rst(rst), .start(start0), .delay_cfg(delay_cfg), .state_in(state_in),
        .wk_valid(wk_valid), .wk_w(wk_w), .wk_k(wk_k), .wk_ready(wk_ready0),
        .fu_run(fu_run0), .fu_state(fu_state0), .fu_w(fu_w0), .fu_k(fu_k0),
        .fu_delay(fu_delay0), .fu_out(fu_out0), .busy(busy0), .done(done0),
        .digest(digest0), .digest_valid(digest_valid0)
    );

    xunitf_sched #(.NCHUNKS(1), .FEEDFWD(0)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .delay_cfg(delay_cfg), .state_in(state_in),
        .wk_valid(wk_valid), .wk_w(wk_w), .wk_k(wk_k), .wk_ready(wk_ready1),
        .fu_run(fu_run1), .fu_state(fu_state1), .fu_w(fu_w1), .fu_k(fu_k1),
        .fu_delay(fu_delay1), .fu_out(fu_out1), .busy(busy1), .done(done1),
        .digest(digest1), .digest_valid(digest_valid1)
    );

    int           nvec = 0;
    int           nbad = 0;
    int           cyc = 0;
    logic [31:0]  ktab [64];
    logic [2047:0] cur_w = '0;
    int           cur_d0 = 0;
    int           cur_d1 = 0;

    localparam logic [255:0] H0 = {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
                                   32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};
    localparam logic [255:0] ABC_DIGEST = {32'hf20015ad, 32'hb410ff61, 32'h96177a9c, 32'hb00361a3,
                                           32'h5dae2223, 32'h414140de, 32'h8f01cfea, 32'hba7816bf};

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] rotr(logic [31:0] x, int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_round(logic [255:0] s, logic [31:0] w, logic [31:0] k);
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        a = s[31:0];    b = s[63:32];   c = s[95:64];   d = s[127:96];
        e = s[159:128]; f = s[191:160]; g = s[223:192]; h = s[255:224];
        t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
        t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
        return {g, f, e, d + t1, c, b, a, t1 + t2};
    endfunction

    function automatic logic [255:0] compress(logic [255:0] init, logic [2047:0] wv, int nr, bit ff);
        logic [255:0] s;
        s = init;
        for (int r = 0; r < nr; r++) s = sha_round(s, wv[r*32 +: 32], ktab[r]);
        if (ff) for (int j = 0; j < 8; j++) s[j*32 +: 32] = s[j*32 +: 32] + init[j*32 +: 32];
        return s;
    endfunction

    function automatic logic [2047:0] abc_sched();
        logic [31:0]   w [64];
        logic [2047:0] p;
        logic [31:0]   s0, s1;
        for (int i = 0; i < 16; i++) w[i] = '0;
        w[0]  = 32'h61626380;
        w[15] = 32'h00000018;
        for (int i = 16; i < 64; i++) begin
            s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        for (int i = 0; i < 64; i++) p[i*32 +: 32] = w[i];
        return p;
    endfunction

    function automatic logic [2047:0] rand_w();
        logic [2047:0] p;
        for (int i = 0; i < 64; i++) p[i*32 +: 32] = $urandom;
        return p;
    endfunction

    // xunitF behavioural model: result only appears on fu_out in the exact capture cycle
    typedef struct {
        bit           active;
        int           t0;
        int           n;
        int           launches;
        int           last_t;
        int           bad;
        int           dly;
        logic [255:0] hold;
        logic [255:0] st;
        logic [255:0] cap;
        logic [255:0] out;
    } fu_t;

    fu_t m0 = '{default: 0};
    fu_t m1 = '{default: 0};

    function automatic fu_t fu_step(fu_t m, logic run, logic [255:0] fst, logic [31:0] w,
                                    logic [31:0] k, logic rdy, int dly, int nch);
        int idx;
        if (run) begin
            m.active = 1; m.t0 = cyc; m.n = 0; m.hold = fst; m.st = fst;
            m.last_t = cyc; m.dly = dly; m.launches++;
            if (rdy) m.bad++;
        end else if (m.active) begin
            if (rdy || fst != m.hold) m.bad++;
            if (m.n < 16 && cyc == m.t0 + 1 + m.n) begin
                idx = ((m.launches - 1) % nch) * 16 + m.n;
                if (w != cur_w[idx*32 +: 32] || k != ktab[idx]) m.bad++;
                m.st = sha_round(m.st, w, k);
                m.n++;
            end
        end
        if (m.active && cyc == m.t0 + 16 + m.dly + 2) begin
            if (m.n != 16) m.bad++;
            m.out = m.st; m.cap = m.st; m.active = 0;
        end else begin
            for (int j = 0; j < 8; j++) m.out[j*32 +: 32] = $urandom;
        end
        return m;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            m0 = '{default: 0}; m1 = '{default: 0};
            fu_out0 = '0; fu_out1 = '0;
        end else begin
            m0 = fu_step(m0, fu_run0, fu_state0, fu_w0, fu_k0, wk_ready0, cur_d0, 4);
            m1 = fu_step(m1, fu_run1, fu_state1, fu_w1, fu_k1, wk_ready1, cur_d1, 1);
            fu_out0 = m0.out;
            fu_out1 = m1.out;
        end
    end

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        nvec++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    task automatic run_block(input bit sel, input logic [255:0] init, input int d, input int bubble,
                             input logic [255:0] exp, input bit poke, input bit abort,
                             input bit start_at_done);
        int nch, target, idx, guard, l0, b0, ndone;
        bit rdy, v, poked;
        nch = sel ? 1 : 4;
        target = abort ? 48 : nch * 16;
        idx = 0; guard = 0; poked = 0; ndone = 0;
        l0 = sel ? m1.launches : m0.launches;
        b0 = sel ? m1.bad : m0.bad;
        if (sel) cur_d1 = d; else cur_d0 = d;
        @(negedge clk);
        state_in = init; delay_cfg = 8'(d);
        if (sel) start1 = 1'b1; else start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0; start1 = 1'b0;
        delay_cfg = 8'($urandom); state_in = {8{32'($urandom)}};
        while (idx < target && guard < 5000) begin
            rdy = sel ? wk_ready1 : wk_ready0;
            v = ($urandom_range(0, 99) >= bubble);
            wk_valid = v; wk_w = cur_w[idx*32 +: 32]; wk_k = ktab[idx];
            if (poke && idx == 20 && !poked) begin start0 = 1'b1; poked = 1; end
            @(negedge clk);
            start0 = 1'b0;
            if (v && rdy) idx++;
            guard++;
        end
        wk_valid = 1'b0;
        check("pairs_accepted", 256'(idx), 256'(target));
        if (abort) begin
            repeat (3) @(negedge clk);
            rst = 1'b0;
            #1;
            check("rst_ctrl_outs", {wk_ready0, fu_run0, busy0, done0, digest_valid0}, '0);
            check("rst_digest", digest0, '0);
            check("rst_fu_state", fu_state0, '0);
            check("rst_fu_wkd", {fu_w0, fu_k0, fu_delay0}, '0);
            repeat (5) begin @(negedge clk); if (done0) ndone++; end
            check("rst_no_done", 256'(ndone), 0);
            rst = 1'b1;
            @(negedge clk);
            return;
        end
        guard = 0;
        while (!(sel ? done1 : done0) && guard < 3000) begin @(negedge clk); guard++; end
        check("done_seen", 256'(guard < 3000), 1);
        check("done_latency", 256'(cyc - (sel ? m1.last_t : m0.last_t)), 256'(20 + d));
        check("digest", sel ? digest1 : digest0, exp);
        check("digest_valid", 256'(sel ? digest_valid1 : digest_valid0), 1);
        check("busy_at_done", 256'(sel ? busy1 : busy0), 0);
        check("fu_run_count", 256'((sel ? m1.launches : m0.launches) - l0), 256'(nch));
        check("fu_feed_errors", 256'((sel ? m1.bad : m0.bad) - b0), 0);
        if (sel) check("digest_is_fu_out", digest1, m1.cap);
        if (start_at_done) begin state_in = ~init; start0 = 1'b1; end
        @(negedge clk);
        start0 = 1'b0;
        check("done_width", 256'(sel ? done1 : done0), 0);
        check("digest_held", sel ? digest1 : digest0, exp);
        if (start_at_done) check("start_on_done_ignored", 256'(busy0), 0);
    endtask

    typedef struct {
        logic [2047:0] w;
        logic [255:0]  init;
        int            d;
        int            bubble;
        bit            poke;
        logic [255:0]  exp;
    } vec_t;

    vec_t tbl [6];

    initial begin
        ktab = '{
            32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
            32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
            32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
            32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
            32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
            32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
            32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
            32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

        tbl[0] = '{abc_sched(), H0, 0, 0, 1'b0, ABC_DIGEST};
        tbl[1] = '{abc_sched(), H0, 5, 0, 1'b0, ABC_DIGEST};
        tbl[2] = '{abc_sched(), H0, 0, 50, 1'b1, ABC_DIGEST};
        tbl[3].w = rand_w(); tbl[3].init = {8{32'($urandom)}}; tbl[3].d = $urandom_range(1, 40);
        tbl[3].bubble = 30; tbl[3].poke = 1'b0;
        tbl[4].w = rand_w(); tbl[4].init = {256{1'b1}}; tbl[4].d = 3; tbl[4].bubble = 20; tbl[4].poke = 1'b0;
        tbl[5].w = rand_w(); tbl[5].init = {8{32'($urandom)}}; tbl[5].d = 255; tbl[5].bubble = 0; tbl[5].poke = 1'b0;
        for (int i = 3; i < 6; i++) tbl[i].exp = compress(tbl[i].init, tbl[i].w, 64, 1'b1);

        repeat (3) @(negedge clk);
        #1;
        check("reset_ctrl_outs", {wk_ready0, fu_run0, busy0, done0, digest_valid0,
                                  wk_ready1, fu_run1, busy1, done1, digest_valid1}, '0);
        check("reset_data_outs", digest0 | fu_state0 | {fu_w0, fu_k0, fu_delay0}, '0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            cur_w = tbl[i].w;
            run_block(1'b0, tbl[i].init, tbl[i].d, tbl[i].bubble, tbl[i].exp, tbl[i].poke, 1'b0, 1'b0);
        end

        cur_w = abc_sched();
        run_block(1'b0, H0, 2, 25, ABC_DIGEST, 1'b0, 1'b1, 1'b0);
        run_block(1'b0, H0, 1, 0, ABC_DIGEST, 1'b0, 1'b0, 1'b1);
        run_block(1'b0, H0, 0, 0, ABC_DIGEST, 1'b0, 1'b0, 1'b0);

        cur_w = rand_w();
        run_block(1'b1, {256{1'b1}}, 4, 20, compress({256{1'b1}}, cur_w, 16, 1'b0), 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
`default_nettype wire
